lfsr_run_ctrl: RTL and testbench

//  Run controller for the 24-bit LFSR / sequence-detector datapath. It seeds the LFSR, then

---
 rtl/lfsr_run_ctrl_if.sv | 26 ++
 rtl/lfsr_run_ctrl.sv | 141 ++++++++++++++
 tb/tb_lfsr_run_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/lfsr_run_ctrl_if.sv
// Control-side handshake between the test/control logic and lfsr_run_ctrl.
// master: requester (start/abort/seed/run_len); slave: the run controller.
interface lfsr_run_ctrl_if #(
    parameter int LFSR_W = 24,
    parameter int CNT_W  = 20,
    parameter int HIT_W  = 16
);
    logic              start;
    logic              abort;
    logic [LFSR_W-1:0] seed;
    logic [CNT_W-1:0]  run_len;
    logic              busy;
    logic              done;
    logic [HIT_W-1:0]  hit_count;
    logic              lockup_err;

    modport master (
        output start, abort, seed, run_len,
        input  busy, done, hit_count, lockup_err
    );

    modport slave (
        input  start, abort, seed, run_len,
        output busy, done, hit_count, lockup_err
    );
endinterface

// File: rtl/lfsr_run_ctrl.sv
// Run controller for the LFSR + sequence-detector pair: seeds the LFSR, steps it
// run_len times, counts detector hits (saturating) and flags all-zero lockup.
// Optional period check enabled by defining LFSR_PERIOD_CHK_EN (adds wrap_seen/wrap_cycle).
module lfsr_run_ctrl #(
    parameter int LFSR_W = 24,
    parameter int CNT_W  = 20,
    parameter int HIT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    lfsr_run_ctrl_if.slave    ctl,
    output logic              lfsr_load,
    output logic [LFSR_W-1:0] lfsr_seed,
    output logic              lfsr_en,
    input  logic [LFSR_W-1:0] lfsr_reg,
    input  logic              seq_detected
`ifdef LFSR_PERIOD_CHK_EN
    ,
    output logic              wrap_seen,
    output logic [CNT_W-1:0]  wrap_cycle
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [LFSR_W-1:0] seed_q,  seed_d;
    logic [CNT_W-1:0]  len_q,   len_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [HIT_W-1:0]  hit_q,   hit_d;
    logic              lock_q,  lock_d;
`ifdef LFSR_PERIOD_CHK_EN
    logic              wrap_seen_q, wrap_seen_d;
    logic [CNT_W-1:0]  wrap_cyc_q,  wrap_cyc_d;
`endif

    // Next-state and datapath updates; abort is checked first so it wins over
    // both terminal count and lockup.
    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        lock_d  = lock_q;
`ifdef LFSR_PERIOD_CHK_EN
        wrap_seen_d = wrap_seen_q;
        wrap_cyc_d  = wrap_cyc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ctl.start) begin
                    seed_d  = ctl.seed;
                    len_d   = ctl.run_len;
                    cnt_d   = '0;
                    hit_d   = '0;
                    lock_d  = (ctl.seed == '0);
`ifdef LFSR_PERIOD_CHK_EN
                    wrap_seen_d = 1'b0;
                    wrap_cyc_d  = '0;
`endif
                    // A zero seed would lock the LFSR, so skip loading it entirely.
                    state_d = (ctl.seed == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (ctl.abort || (len_q == '0)) state_d = S_DONE;
                else                            state_d = S_RUN;
            end
            S_RUN: begin
                if (seq_detected && (hit_q != '1)) hit_d = hit_q + HIT_W'(1);
`ifdef LFSR_PERIOD_CHK_EN
                // cnt_q counts completed steps, so cnt_q != 0 excludes the seed itself.
                if ((cnt_q != '0) && (lfsr_reg == seed_q) && !wrap_seen_q) begin
                    wrap_seen_d = 1'b1;
                    wrap_cyc_d  = cnt_q;
                end
`endif
                if (ctl.abort) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (lfsr_reg == '0) begin
                        lock_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (cnt_q == len_q - CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            seed_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            hit_q   <= '0;
            lock_q  <= 1'b0;
`ifdef LFSR_PERIOD_CHK_EN
            wrap_seen_q <= 1'b0;
            wrap_cyc_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            lock_q  <= lock_d;
`ifdef LFSR_PERIOD_CHK_EN
            wrap_seen_q <= wrap_seen_d;
            wrap_cyc_q  <= wrap_cyc_d;
`endif
        end
    end

    // Outputs decode from registered state; lfsr_en additionally gated by abort.
    assign ctl.busy       = (state_q != S_IDLE);
    assign ctl.done       = (state_q == S_DONE);
    assign ctl.hit_count  = hit_q;
    assign ctl.lockup_err = lock_q;
    assign lfsr_load      = (state_q == S_LOAD);
    assign lfsr_seed      = seed_q;
    assign lfsr_en        = (state_q == S_RUN) && !ctl.abort;
`ifdef LFSR_PERIOD_CHK_EN
    assign wrap_seen      = wrap_seen_q;
    assign wrap_cycle     = wrap_cyc_q;
`endif

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// Directed bench for lfsr_run_ctrl: one linear sequence of runs with hand-computed
// latencies, enable counts, hit counts and lockup flags.
module tb_lfsr_run_ctrl;

    logic        clk;
    logic        reset_n;
    logic        lfsr_load;
    logic [23:0] lfsr_seed;
    logic        lfsr_en;
    logic [23:0] lfsr_reg;
    logic        seq_detected;
`ifdef LFSR_PERIOD_CHK_EN
    logic        wrap_seen;
    logic [19:0] wrap_cycle;
`endif

    int checks   = 0;
    int failures = 0;

    lfsr_run_ctrl_if #(.LFSR_W(24), .CNT_W(20), .HIT_W(16)) ctl ();

    lfsr_run_ctrl #(.LFSR_W(24), .CNT_W(20), .HIT_W(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ctl          (ctl),
        .lfsr_load    (lfsr_load),
        .lfsr_seed    (lfsr_seed),
        .lfsr_en      (lfsr_en),
        .lfsr_reg     (lfsr_reg),
        .seq_detected (seq_detected)
`ifdef LFSR_PERIOD_CHK_EN
        ,
        .wrap_seen    (wrap_seen),
        .wrap_cycle   (wrap_cycle)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one start and follow the run. lat=k means the k-th cycle after the edge
    // that sampled start; inputs for a cycle are set at its negedge, outputs read 1ns later.
    task automatic run(input logic [23:0] sd, input logic [19:0] len,
                       input int abort_lat, input int seqa, input int seqb, input bit seq_all,
                       input int zero_lat, input int start_lat, input int max_cyc,
                       output int n_load, output int n_en, output int done_lat,
                       output logic [15:0] hit, output logic lock);
        n_load = 0; n_en = 0; done_lat = -1; hit = '0; lock = 1'b0;
        @(negedge clk);
        ctl.seed = sd; ctl.run_len = len; ctl.start = 1'b1;
        for (int lat = 1; lat <= max_cyc; lat++) begin
            @(negedge clk);
            ctl.start    = (lat == start_lat);
            ctl.abort    = (lat == abort_lat);
            seq_detected = seq_all || (lat == seqa) || (lat == seqb);
            lfsr_reg     = (lat == zero_lat) ? 24'h0 : 24'h5A5A5A;
            #1;
            if (lfsr_load) n_load++;
            if (lfsr_en)   n_en++;
            if (ctl.done) begin
                done_lat = lat;
                hit      = ctl.hit_count;
                lock     = ctl.lockup_err;
                break;
            end
        end
        ctl.start = 1'b0; ctl.abort = 1'b0; seq_detected = 1'b0; lfsr_reg = 24'h5A5A5A;
    endtask

    initial begin
        int          nl, ne, dl;
        logic [15:0] h;
        logic        lk;

        reset_n = 1'b0;
        ctl.start = 1'b0; ctl.abort = 1'b0; ctl.seed = '0; ctl.run_len = '0;
        seq_detected = 1'b0; lfsr_reg = 24'h5A5A5A;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(ctl.busy), 0);
        chk("rst_done", 32'(ctl.done), 0);
        chk("rst_load", 32'(lfsr_load), 0);
        chk("rst_en",   32'(lfsr_en), 0);
        chk("rst_hit",  32'(ctl.hit_count), 0);
        chk("rst_lock", 32'(ctl.lockup_err), 0);
        chk("rst_seed", 32'(lfsr_seed), 0);
        reset_n = 1'b1;

        // LFSR reads zero in RUN cycle 3: that step still enabled, then DONE.
        run(24'h000005, 20'd20, 0, 0, 0, 0, 4, 0, 100, nl, ne, dl, h, lk);
        chk("lk_load", 32'(nl), 1);
        chk("lk_en",   32'(ne), 3);
        chk("lk_done", 32'(dl), 5);
        chk("lk_lock", 32'(lk), 1);

        // Basic run, hits in RUN cycles 3 and 7; lockup from previous run cleared.
        run(24'h000001, 20'd10, 0, 4, 8, 0, 0, 0, 100, nl, ne, dl, h, lk);
        chk("t1_load", 32'(nl), 1);
        chk("t1_en",   32'(ne), 10);
        chk("t1_done", 32'(dl), 12);
        chk("t1_hit",  32'(h), 2);
        chk("t1_lock", 32'(lk), 0);
        chk("t1_seed", 32'(lfsr_seed), 32'h000001);

        // Zero seed: straight to DONE.
        run(24'h000000, 20'd10, 0, 2, 0, 0, 0, 0, 100, nl, ne, dl, h, lk);
        chk("t2_load", 32'(nl), 0);
        chk("t2_en",   32'(ne), 0);
        chk("t2_done", 32'(dl), 1);
        chk("t2_lock", 32'(lk), 1);
        chk("t2_hit",  32'(h), 0);

        // Abort in RUN cycle 5, with a stray start during RUN.
        run(24'h00ACE1, 20'd100, 6, 0, 0, 0, 0, 4, 200, nl, ne, dl, h, lk);
        chk("t3_load", 32'(nl), 1);
        chk("t3_en",   32'(ne), 4);
        chk("t3_done", 32'(dl), 7);
        chk("t3_lock", 32'(lk), 0);
        repeat (2) @(negedge clk);
        #1;
        chk("t3_noq_busy", 32'(ctl.busy), 0);

        // Abort while in LOAD.
        run(24'h000777, 20'd30, 1, 0, 0, 0, 0, 0, 100, nl, ne, dl, h, lk);
        chk("ab_load", 32'(nl), 1);
        chk("ab_en",   32'(ne), 0);
        chk("ab_done", 32'(dl), 2);

        // Zero run length.
        run(24'hABCDEF, 20'd0, 0, 0, 0, 0, 0, 0, 100, nl, ne, dl, h, lk);
        chk("t5_load", 32'(nl), 1);
        chk("t5_en",   32'(ne), 0);
        chk("t5_done", 32'(dl), 2);
        chk("t5_hit",  32'(h), 0);
        chk("t5_seed", 32'(lfsr_seed), 32'hABCDEF);

        // Long run with detector stuck high: hit counter saturates.
        run(24'h123456, 20'd70000, 0, 0, 0, 1, 0, 0, 70100, nl, ne, dl, h, lk);
        chk("t4_en",   32'(ne), 70000);
        chk("t4_done", 32'(dl), 70002);
        chk("t4_hit",  32'(h), 32'hFFFF);
        @(negedge clk); #1;
        chk("t4_hold", 32'(ctl.hit_count), 32'hFFFF);

        // Async reset mid-RUN, between clock edges.
        @(negedge clk);
        ctl.seed = 24'h000007; ctl.run_len = 20'd50; ctl.start = 1'b1; seq_detected = 1'b1;
        @(negedge clk); ctl.start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("t6_pre_en", 32'(lfsr_en), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_busy", 32'(ctl.busy), 0);
        chk("t6_en",   32'(lfsr_en), 0);
        chk("t6_load", 32'(lfsr_load), 0);
        chk("t6_done", 32'(ctl.done), 0);
        chk("t6_hit",  32'(ctl.hit_count), 0);
        seq_detected = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk); #1;
        chk("t6_idle", 32'(ctl.busy), 0);

        run(24'h000003, 20'd5, 0, 2, 0, 0, 0, 0, 100, nl, ne, dl, h, lk);
        chk("t6r_load", 32'(nl), 1);
        chk("t6r_en",   32'(ne), 5);
        chk("t6r_done", 32'(dl), 7);
        chk("t6r_hit",  32'(h), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
